// File: rtl/bcd_down_counter_pkg.sv
// ---------------------------------------------------------------------------
// bcd_down_counter_pkg
//   Shared definitions for the BCD countdown timer: FSM state encoding,
//   BCD digit width/limits and the preset sanitising helper.
//   No ports; imported by bcd_down_counter and bcd_down_digit.
// ---------------------------------------------------------------------------
package bcd_down_counter_pkg;

  // Width of one decade digit and the largest legal BCD value.
  localparam int unsigned BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  // Countdown controller states. Encodings are fixed so the display and
  // debug paths can decode them without going through the enum.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Clamp a nibble to a legal BCD digit: anything above 9 becomes 9, so a
  // garbage preset still yields the longest countdown for that digit rather
  // than an illegal code that would break the borrow chain.
  function automatic logic [3:0] sanitiseNibble(input logic [3:0] nibble);
    logic [3:0] result;
    result = nibble;
    if (nibble > BCD_MAX) begin
      result = BCD_MAX;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_down_counter_digit.sv
// ---------------------------------------------------------------------------
// bcd_down_digit
//   One decade cell of the BCD down-counter. Holds a single BCD digit,
//   loads a (pre-sanitised) value, and decrements with 0 -> 9 wrap.
//
//   Ports
//     clk_i         rising-edge clock
//     rst_ni        asynchronous active-low reset (digit clears to 0)
//     load_i        load load_val_i this cycle (wins over dec_i)
//     load_val_i    legal BCD value to load
//     dec_i         borrow-in: decrement this digit this cycle
//     digit_o       current digit value
//     is_zero_o     digit_o == 0
//     borrow_out_o  dec_i & digit == 0, i.e. this digit wraps and the next
//                   more-significant digit must decrement
// ---------------------------------------------------------------------------
module bcd_down_digit
  import bcd_down_counter_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             is_zero_o,
  output logic             borrow_out_o
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;
  logic             digitIsZero;

  assign digitIsZero = (digit_q == '0);

  // Next digit value: a load replaces the digit outright; otherwise a borrow
  // in steps it down, wrapping 0 back to 9.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (dec_i) begin
      if (digitIsZero) begin
        digit_d = BCD_MAX;
      end else begin
        digit_d = digit_q - 4'd1;
      end
    end
  end

  // Digit storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o      = digit_q;
  assign is_zero_o    = digitIsZero;
  assign borrow_out_o = dec_i & digitIsZero;

endmodule

// File: rtl/bcd_down_counter.sv
// ---------------------------------------------------------------------------
// bcd_down_counter
//   Multi-digit BCD countdown timer. Loads a decimal preset, counts down one
//   step per enabled tick while running, and pulses done when it lands on 0.
//
//   Parameters
//     DIGITS      number of BCD digits (1..8), digit 0 least significant
//
//   Ports
//     clk_i       rising-edge clock
//     rst_ni      asynchronous active-low reset
//     load_i      load sanitised preset, return to IDLE (highest priority)
//     preset_i    BCD preset, nibble i = digit i (nibbles > 9 load as 9)
//     start_i     begin countdown (honoured in IDLE only)
//     en_i        decrement tick (honoured in RUN only)
//     digits_o    current BCD value, nibble i = digit i
//     busy_o      high while in RUN (registered)
//     zero_o      all digits are 0 (combinational on digits_o)
//     done_o      single-cycle pulse on entering DONE
// ---------------------------------------------------------------------------
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [BCD_W*DIGITS-1:0] preset_i,
  input  logic                    start_i,
  input  logic                    en_i,
  output logic [BCD_W*DIGITS-1:0] digits_o,
  output logic                    busy_o,
  output logic                    zero_o,
  output logic                    done_o
);

  state_e state_q;
  state_e state_d;
  logic   done_q;
  logic   done_d;

  logic                    decEn;
  logic                    oneLeft;
  logic                    allZero;
  logic [BCD_W*DIGITS-1:0] loadVal;
  logic [BCD_W*DIGITS-1:0] digitVal;
  logic [DIGITS-1:0]       isZero;
  logic [DIGITS:0]         borrow;

  // Borrow chain: digit 0 takes the tick directly, every higher digit takes
  // the borrow-out of the one below, so a digit only moves when all lower
  // digits were 0 before the tick.
  assign borrow[0] = decEn;

  for (genvar g = 0; g < DIGITS; g++) begin : gDigit
    assign loadVal[BCD_W*g +: BCD_W] = sanitiseNibble(preset_i[BCD_W*g +: BCD_W]);

    bcd_down_digit uDigit (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .load_i       (load_i),
      .load_val_i   (loadVal[BCD_W*g +: BCD_W]),
      .dec_i        (borrow[g]),
      .digit_o      (digitVal[BCD_W*g +: BCD_W]),
      .is_zero_o    (isZero[g]),
      .borrow_out_o (borrow[g+1])
    );
  end

  assign allZero = &isZero;

  // Detect the value 1 (digit 0 == 1, every higher digit 0). The next tick
  // from here lands on 0 and must end the countdown.
  always_comb begin
    oneLeft = (digitVal[BCD_W-1:0] == 4'd1);
    for (int i = 1; i < DIGITS; i++) begin
      oneLeft = oneLeft & isZero[i];
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. load pre-empts everything; start and en are only
  // looked at in the state that owns them. A borrow out of the top digit
  // can only mean RUN somehow holds 0; stopping in DONE keeps the counter
  // from free-running through 9s in that case.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = allZero ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (en_i && (oneLeft || borrow[DIGITS])) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output/control logic: the decrement strobe for the digit chain and the
  // done pulse, which fires only on the cycle DONE is entered.
  always_comb begin
    decEn  = 1'b0;
    done_d = 1'b0;
    if (!load_i) begin
      decEn  = (state_q == ST_RUN) && en_i;
      done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  // done is registered so it lines up with the DONE state and digits == 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign digits_o = digitVal;
  assign busy_o   = (state_q == ST_RUN);
  assign zero_o   = allZero;
  assign done_o   = done_q;

endmodule
